// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_t  - per-slot FSM state (BLANK, DRIVE)
//   SEG_OFF       - all segments dark (active-low)
//   AN_OFF        - all anodes off (active-low)
//   NUM_DIGITS    - digits sharing the cathode bus
package sevenseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [3:0]  AN_OFF     = 4'hF;
    localparam int unsigned NUM_DIGITS = 4;

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if: data-load and display-pin bundle of the scan controller.
//   load        - single-cycle request to capture display data
//   value_in    - one hex nibble per digit, digit 0 in [3:0]
//   dp_in       - decimal point per digit, 1 = lit
//   en_in       - digit enable, 0 = dark
//   an          - anode drives, active-low
//   seg         - segments a..g (bit 0 = a), active-low
//   dp          - decimal point, active-low
//   frame_done  - one-cycle pulse after the last slot of each frame
// master: the value source; slave: the scan controller.
interface sevenseg_scan_ctrl_if;
    import sevenseg_pkg::*;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output load, value_in, dp_in, en_in,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  load, value_in, dp_in, en_in,
        output an, seg, dp, frame_done
    );

endinterface

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to active-low seven-segment glyph (0-9, A, b, C, d, E, F).
//   nib - hex digit
//   seg - segments a..g, bit 0 = a, 0 = lit
module hex7seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    import sevenseg_pkg::*;

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed scan of four digits on a shared cathode bus.
// Each digit slot is TICK_DIV cycles; the first BLANK_CYCLES of a slot keep all
// anodes off to suppress ghosting. Display data is double-buffered and only
// becomes active on the frame boundary (last cycle of digit 3's slot).
//   clk  - system clock
//   rst  - asynchronous reset, active-low
//   bus  - sevenseg_scan_ctrl_if.slave (load/value_in/dp_in/en_in in,
//          an/seg/dp/frame_done out, all outputs registered)
// Optional build macro SEVENSEG_LEADING_ZERO_BLANK_EN: suppress leading-zero
// digits (digit 0 always shown; a suppressed digit with dp set shows dp only).
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic                clk,
    input  logic                rst,
    sevenseg_scan_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(NUM_DIGITS);
    localparam int unsigned VW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST       = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIG_LAST       = DW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [DW-1:0]         d;
    logic                  cnt_wrap;
    logic                  boundary;
    scan_state_t           state, state_nx;

    logic [VW-1:0]         act_val, pend_val;
    logic [NUM_DIGITS-1:0] act_dp, act_en, pend_dp, pend_en;
    logic                  pend;

    logic [3:0]            nib;
    logic [6:0]            seg_dec;
    logic                  show;
    logic [NUM_DIGITS-1:0] an_nx, an_q;
    logic [6:0]            seg_nx, seg_q;
    logic                  dp_nx, dp_q, fd_q;

    assign cnt_wrap = (cnt == CNT_LAST);
    assign boundary = cnt_wrap && (d == DIG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            d   <= '0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            d   <= (d == DIG_LAST) ? '0 : d + DW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BLANK;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            BLANK: if (cnt == CNT_BLANK_LAST) state_nx = DRIVE;
            DRIVE: if (cnt_wrap)              state_nx = BLANK;
            default: state_nx = BLANK;
        endcase
    end

    // A load on the boundary cycle goes straight to the active set; otherwise
    // it parks in pending, which is promoted (and cleared) at the boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_val  <= '0;
            act_dp   <= '0;
            act_en   <= '1;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_en  <= '0;
            pend     <= 1'b0;
        end else if (boundary) begin
            if (bus.load) begin
                act_val <= bus.value_in;
                act_dp  <= bus.dp_in;
                act_en  <= bus.en_in;
            end else if (pend) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                act_en  <= pend_en;
            end
            pend <= 1'b0;
        end else if (bus.load) begin
            pend_val <= bus.value_in;
            pend_dp  <= bus.dp_in;
            pend_en  <= bus.en_in;
            pend     <= 1'b1;
        end
    end

    assign nib = act_val[{d, 2'b00} +: 4];

    hex7seg u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    // lz[i]: nibble i and every higher nibble are zero; digit 0 never qualifies.
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        lz = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            lz[i] = ((act_val >> (4 * i)) == '0);
        end
    end
`endif

    always_comb begin
        an_nx  = AN_OFF;
        seg_nx = SEG_OFF;
        dp_nx  = 1'b1;
        show   = 1'b0;
        if (state == DRIVE) begin
            seg_nx = seg_dec;
            dp_nx  = ~act_dp[d];
            show   = act_en[d];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
            if (lz[d]) begin
                if (act_dp[d]) seg_nx = SEG_OFF;
                else           show   = 1'b0;
            end
`endif
            if (show) an_nx[d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_nx;
            seg_q <= seg_nx;
            dp_q  <= dp_nx;
            fd_q  <= boundary;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule
